// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM states, the default
// reset PC and the next-PC source encoding.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // Clears the byte-offset bits of a register jump target.
    localparam logic [31:0] JR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2,
        ERROR      = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_sel_e;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > pc+4.
// With PC_MISALIGN_TRAP_EN defined, a jr to a non-word-aligned address
// raises jr_trap so the fetch unit can stop; otherwise jr_trap is tied low
// and the target's low two bits are simply cleared.
module pc_next_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        jr_trap
);

    npc_sel_e    sel;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_aligned;

    // Form every candidate target in parallel, then pick one by priority.
    always_comb begin
        pc_plus4      = pc + 32'd4;
        branch_taken  = (branch_eq & zero) | (branch_ne & ~zero);
        branch_target = pc_plus4 + branch_offset(br_imm);
        jump_target   = {pc_plus4[31:28], j_index, 2'b00};
        jr_aligned    = jr_target & JR_ALIGN_MASK;

        sel = NPC_PLUS4;
        if (jr) begin
            sel = NPC_JR;
        end else if (jump) begin
            sel = NPC_JUMP;
        end else if (branch_taken) begin
            sel = NPC_BRANCH;
        end

        case (sel)
            NPC_JR:     next_pc = jr_aligned;
            NPC_JUMP:   next_pc = jump_target;
            NPC_BRANCH: next_pc = branch_target;
            default:    next_pc = pc_plus4;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign jr_trap = jr & (jr_target[1:0] != 2'b00);
`else
    assign jr_trap = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the PC and instruction registers and the
// RESET_WAIT/FETCH/HOLD/ERROR sequencer. Each instruction is requested in
// FETCH, presented downstream in HOLD until acknowledged, and the PC is
// advanced on the acknowledge. ERROR is reachable only when
// PC_MISALIGN_TRAP_EN is defined (see pc_next_calc).
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_index,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  next_pc;
    logic         jr_trap;

    pc_next_calc u_next (
        .pc        (pc_q),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .jump      (jump),
        .zero      (zero),
        .jr        (jr),
        .jr_target (jr_target),
        .br_imm    (br_imm),
        .j_index   (j_index),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc),
        .jr_trap   (jr_trap)
    );

    // State, PC, instruction and error flag; reset abandons any fetch in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_WAIT;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    // Sequencer: request, capture, hold until acknowledged, then advance the PC.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        misalign_d  = misalign_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        case (state_q)
            RESET_WAIT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    if (jr_trap) begin
                        misalign_d = 1'b1;
                        state_d    = ERROR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase
    end

    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the stimulus side pushes expected fetch
// addresses and captured instructions into queues, a negedge monitor pops and
// compares whenever the DUT requests memory or presents a new instruction.
module tb_pc_fetch_unit;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        zero;
    logic        jr;
    logic [31:0] jr_target;
    logic [15:0] br_imm;
    logic [25:0] j_index;
    logic        misalign_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] addr_q[$];
    fetch_exp_t  fetch_q[$];
    logic [31:0] model_pc;
    logic        prev_valid = 1'b0;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ack    (instr_ack),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .branch_eq    (branch_eq),
        .branch_ne    (branch_ne),
        .jump         (jump),
        .zero         (zero),
        .jr           (jr),
        .jr_target    (jr_target),
        .br_imm       (br_imm),
        .j_index      (j_index),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string what);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Reference next-PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] modelNextPc(input logic [31:0] cur,
            input logic beq, input logic bne, input logic jmp, input logic zr,
            input logic jrs, input logic [31:0] jt, input logic [15:0] bi,
            input logic [25:0] ji);
        logic [31:0] p4;
        int          disp;
        p4 = cur + 32'd4;
        if (jrs) return jt & 32'hFFFF_FFFC;
        if (jmp) return (p4 & 32'hF000_0000) | (32'(ji) * 32'd4);
        if ((beq && zr) || (bne && !zr)) begin
            disp = int'($signed(bi));
            return p4 + 32'(disp * 4);
        end
        return p4;
    endfunction

    // Monitor: compare request address while requesting, and each newly presented instruction.
    always @(negedge clk) begin
        fetch_exp_t e;
        if (!reset) begin
            if (imem_req) begin
                if (addr_q.size() == 0) begin
                    reportFail("unexpected_req", $sformatf("request at %h with nothing expected", imem_addr));
                end else begin
                    checkOutput("imem_addr", imem_addr, addr_q[0]);
                    if (imem_ready) void'(addr_q.pop_front());
                end
                if (instr_valid) reportFail("req_and_valid", "imem_req and instr_valid both high");
            end
            if (instr_valid && !prev_valid) begin
                if (fetch_q.size() == 0) begin
                    reportFail("unexpected_valid", $sformatf("instr %h with nothing expected", instr));
                end else begin
                    e = fetch_q.pop_front();
                    checkOutput("instr", instr, e.instr);
                    checkOutput("pc", pc, e.pc);
                    checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
                end
            end
        end
        prev_valid = instr_valid;
    end

    task automatic waitReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        reportFail("wait_req", "imem_req timeout");
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        reportFail("wait_valid", "instr_valid timeout");
    endtask

    task automatic randomControls();
        branch_eq = 1'($urandom); branch_ne = 1'($urandom);
        jump = 1'($urandom);      zero = 1'($urandom);
        jr = 1'($urandom);        jr_target = $urandom;
        br_imm = 16'($urandom);   j_index = 26'($urandom);
    endtask

    task automatic doReset();
        reset = 1'b1;
        addr_q.delete();
        fetch_q.delete();
        #1;
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_pc = RST_PC;
        addr_q.push_back(RST_PC);
        #1;
        checkOutput("reset_wait_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        checkOutput("first_fetch_req", 32'(imem_req), 32'd1);
    endtask

    // One fetch/acknowledge transaction with the given decoder controls at ack time.
    task automatic applyStimulus(input logic beq, input logic bne, input logic jmp,
            input logic zr, input logic jrs, input logic [31:0] jt,
            input logic [15:0] bi, input logic [25:0] ji,
            input int stall, input int ack_delay);
        bit          ok;
        logic [31:0] rdata;
        bit          trap;
        waitReq(ok);
        if (!ok) return;
        imem_ready = 1'b0;
        repeat (stall) begin
            instr_ack = 1'($urandom);
            @(posedge clk); #1;
        end
        rdata = $urandom;
        imem_rdata = rdata;
        imem_ready = 1'b1;
        instr_ack = 1'($urandom);
        fetch_q.push_back('{pc: model_pc, instr: rdata});
        @(posedge clk); #1;
        imem_ready = 1'b0;
        instr_ack = 1'b0;
        imem_rdata = $urandom;
        waitValid(ok);
        if (!ok) return;
        repeat (ack_delay) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            randomControls();
            @(posedge clk); #1;
            checkOutput("hold_instr", instr, rdata);
        end
        branch_eq = beq; branch_ne = bne; jump = jmp; zero = zr;
        jr = jrs; jr_target = jt; br_imm = bi; j_index = ji;
        instr_ack = 1'b1;
        trap = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        trap = jrs && (jt % 4 != 0);
`endif
        if (!trap) begin
            model_pc = modelNextPc(model_pc, beq, bne, jmp, zr, jrs, jt, bi, ji);
            addr_q.push_back(model_pc);
        end
        @(posedge clk); #1;
        instr_ack = 1'b0;
        imem_ready = 1'b0;
        randomControls();
        if (trap) begin
            repeat (3) begin
                checkOutput("trap_misalign", 32'(misalign_err), 32'd1);
                checkOutput("trap_req", 32'(imem_req), 32'd0);
                checkOutput("trap_valid", 32'(instr_valid), 32'd0);
                checkOutput("trap_pc", pc, model_pc);
                instr_ack = 1'b1;
                imem_ready = 1'b1;
                @(posedge clk); #1;
            end
            instr_ack = 1'b0;
            imem_ready = 1'b0;
        end else begin
            checkOutput("ack_valid_drop", 32'(instr_valid), 32'd0);
            checkOutput("no_misalign", 32'(misalign_err), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] jt;
        reset = 1'b0;
        imem_rdata = '0; imem_ready = 1'b0; instr_ack = 1'b0;
        branch_eq = 1'b0; branch_ne = 1'b0; jump = 1'b0; zero = 1'b0;
        jr = 1'b0; jr_target = '0; br_imm = '0; j_index = '0;
        model_pc = RST_PC;
        @(posedge clk); #1;
        doReset();

        // First fetch from the reset PC, then sequential advance.
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 0, 0);

        // Backward branch taken, then the same branch not taken.
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_0010, 16'h0, 26'h0, 1, 1);
        applyStimulus(1, 0, 0, 1, 0, 32'h0, 16'hFFFC, 26'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_0010, 16'h0, 26'h0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 32'h0, 16'hFFFC, 26'h0, 2, 0);

        // jr wins over jump.
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_0000, 16'h0, 26'h0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 32'h0040_0100, 16'h0, 26'h3FF_FFFF, 0, 1);

        // Absolute jump using the upper nibble of pc+4.
        applyStimulus(0, 0, 1, 0, 0, 32'h0, 16'h0, 26'h123_4567, 1, 0);

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 16'h0, 26'h0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 0, 0);

        // Misaligned register jump: traps when enabled, aligns otherwise.
        applyStimulus(0, 0, 0, 0, 1, 32'h0040_0102, 16'h0, 26'h0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        doReset();
`endif

        // Long memory stall interrupted by reset: fetch abandoned, PC back to reset value.
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 0, 0);
        begin
            bit ok;
            waitReq(ok);
            imem_ready = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            checkOutput("stall_req", 32'(imem_req), 32'd1);
            doReset();
        end

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            jt = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
            jt = jt & 32'hFFFF_FFFC;
`endif
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                          1'($urandom), ($urandom_range(0, 5) == 0), jt,
                          16'($urandom), 26'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 2));
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
